// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcode/func/ALU constants and the control bundle type
//
// Purpose : constants and types shared by the control decoder and the
//           pipelined control unit.
// Ports   : none (package).
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic       reg_write;
        logic       reg_dest;
        logic       alu_src;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       mem_write;
        logic       mem_to_reg;
        logic [2:0] alu_ctrl;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode/func to control bundle decoder
//
// Purpose : decodes the ID-stage instruction fields into a control bundle.
//           Undecodable opcodes or R-type funcs yield the all-zero bundle.
// Ports   : opcode  in  instruction[31:26]
//           func    in  instruction[5:0]
//           illegal out undecodable instruction (only with CTRL_ILLEGAL_TRAP_EN)
//           ctrl    out decoded control bundle
//           rt_used out instruction reads rt as a source register
// Config  : CTRL_ILLEGAL_TRAP_EN adds the illegal output.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   func,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic         illegal,
`endif
    output ctrl_bundle_t ctrl,
    output logic         rt_used
);

    always_comb begin
        ctrl    = CTRL_BUBBLE;
        rt_used = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal = 1'b0;
`endif
        case (opcode)
            OP_RTYPE: begin
                rt_used        = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.reg_dest  = 1'b1;
                case (func)
                    FN_ADD:  ctrl.alu_ctrl = ALU_ADD;
                    FN_SUB:  ctrl.alu_ctrl = ALU_SUB;
                    FN_AND:  ctrl.alu_ctrl = ALU_AND;
                    FN_OR:   ctrl.alu_ctrl = ALU_OR;
                    FN_SLT:  ctrl.alu_ctrl = ALU_SLT;
                    default: begin
                        ctrl = CTRL_BUBBLE;
`ifdef CTRL_ILLEGAL_TRAP_EN
                        illegal = 1'b1;
`endif
                    end
                endcase
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_ctrl   = ALU_ADD;
            end
            OP_SW: begin
                rt_used        = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_ctrl  = ALU_ADD;
            end
            OP_BEQ: begin
                rt_used       = 1'b1;
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
            end
            OP_BNE: begin
                rt_used        = 1'b1;
                ctrl.branch_ne = 1'b1;
                ctrl.alu_ctrl  = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = ALU_ADD;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                illegal = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// rtl/ctrl_pipe_unit.sv - pipelined MIPS control unit with load-use stall detection
//
// Purpose : decodes the ID instruction, carries its controls through the
//           ID/EX, EX/MEM and MEM/WB registers, and raises a one-cycle stall
//           when the ID instruction reads the destination of a load in EX.
// Ports   : clk, rst (sync active-high)
//           valid_id, flush_id, opcode, func, rs, rt   ID-stage inputs
//           stall                                      combinational hold request
//           illegal_op                                 sticky trap (CTRL_ILLEGAL_TRAP_EN only)
//           ex_*                                       ID/EX controls, ALU op, rt
//           mem_RegWrite, mem_MemWrite, mem_MemtoReg   EX/MEM controls
//           wb_RegWrite, wb_MemtoReg                   MEM/WB controls
// Config  : CTRL_ILLEGAL_TRAP_EN adds the illegal_op output.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W    = 3,
    parameter int REG_W        = 5,
    parameter int LOAD_USE_DET = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_id,
    input  logic                 flush_id,
    input  logic [5:0]           opcode,
    input  logic [5:0]           func,
    input  logic [REG_W-1:0]     rs,
    input  logic [REG_W-1:0]     rt,
    output logic                 stall,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic                 illegal_op,
`endif
    output logic                 ex_RegWrite,
    output logic                 ex_RegDest,
    output logic                 ex_ALUSrc,
    output logic                 ex_Branch,
    output logic                 ex_BranchNe,
    output logic                 ex_Jump,
    output logic                 ex_MemWrite,
    output logic                 ex_MemtoReg,
    output logic [ALUCTRL_W-1:0] ex_ALUControl,
    output logic [REG_W-1:0]     ex_rt,
    output logic                 mem_RegWrite,
    output logic                 mem_MemWrite,
    output logic                 mem_MemtoReg,
    output logic                 wb_RegWrite,
    output logic                 wb_MemtoReg
);

    ctrl_bundle_t dec_ctrl;
    ctrl_bundle_t ex_ctrl;
    logic         dec_rt_used;
    logic         load_use;
    logic         advance;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic         dec_illegal;
`endif

    ctrl_decode u_decode (
        .opcode  (opcode),
        .func    (func),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .illegal (dec_illegal),
`endif
        .ctrl    (dec_ctrl),
        .rt_used (dec_rt_used)
    );

    // A load writing $0 produces no real value, so it never forces a stall.
    assign load_use = ex_ctrl.mem_to_reg & ex_ctrl.reg_write & (ex_rt != '0)
                    & ((ex_rt == rs) | (dec_rt_used & (ex_rt == rt)));

    // Flush and invalid ID both mask the stall: nothing real is waiting.
    assign stall   = (LOAD_USE_DET != 0) & valid_id & ~flush_id & load_use;
    assign advance = valid_id & ~flush_id & ~stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl      <= CTRL_BUBBLE;
            ex_rt        <= '0;
            mem_RegWrite <= 1'b0;
            mem_MemWrite <= 1'b0;
            mem_MemtoReg <= 1'b0;
            wb_RegWrite  <= 1'b0;
            wb_MemtoReg  <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_op   <= 1'b0;
`endif
        end else begin
            if (advance) begin
                ex_ctrl <= dec_ctrl;
                ex_rt   <= rt;
            end else begin
                ex_ctrl <= CTRL_BUBBLE;
                ex_rt   <= '0;
            end
            // Downstream stages never stall; they always drain.
            mem_RegWrite <= ex_ctrl.reg_write;
            mem_MemWrite <= ex_ctrl.mem_write;
            mem_MemtoReg <= ex_ctrl.mem_to_reg;
            wb_RegWrite  <= mem_RegWrite;
            wb_MemtoReg  <= mem_MemtoReg;
`ifdef CTRL_ILLEGAL_TRAP_EN
            if (advance & dec_illegal) begin
                illegal_op <= 1'b1;
            end
`endif
        end
    end

    assign ex_RegWrite   = ex_ctrl.reg_write;
    assign ex_RegDest    = ex_ctrl.reg_dest;
    assign ex_ALUSrc     = ex_ctrl.alu_src;
    assign ex_Branch     = ex_ctrl.branch;
    assign ex_BranchNe   = ex_ctrl.branch_ne;
    assign ex_Jump       = ex_ctrl.jump;
    assign ex_MemWrite   = ex_ctrl.mem_write;
    assign ex_MemtoReg   = ex_ctrl.mem_to_reg;
    assign ex_ALUControl = ALUCTRL_W'(ex_ctrl.alu_ctrl);

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// tb/tb_ctrl_pipe_unit.sv - self-checking bench for ctrl_pipe_unit
module tb_ctrl_pipe_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_id = 1'b0;
    logic       flush_id = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] func = '0;
    logic [4:0] rs = '0;
    logic [4:0] rt = '0;
    logic       stall;
    logic       ex_RegWrite, ex_RegDest, ex_ALUSrc, ex_Branch, ex_BranchNe, ex_Jump;
    logic       ex_MemWrite, ex_MemtoReg;
    logic [2:0] ex_ALUControl;
    logic [4:0] ex_rt;
    logic       mem_RegWrite, mem_MemWrite, mem_MemtoReg;
    logic       wb_RegWrite, wb_MemtoReg;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    ctrl_pipe_unit dut (
        .clk           (clk),
        .rst           (rst),
        .valid_id      (valid_id),
        .flush_id      (flush_id),
        .opcode        (opcode),
        .func          (func),
        .rs            (rs),
        .rt            (rt),
        .stall         (stall),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .illegal_op    (illegal_op),
`endif
        .ex_RegWrite   (ex_RegWrite),
        .ex_RegDest    (ex_RegDest),
        .ex_ALUSrc     (ex_ALUSrc),
        .ex_Branch     (ex_Branch),
        .ex_BranchNe   (ex_BranchNe),
        .ex_Jump       (ex_Jump),
        .ex_MemWrite   (ex_MemWrite),
        .ex_MemtoReg   (ex_MemtoReg),
        .ex_ALUControl (ex_ALUControl),
        .ex_rt         (ex_rt),
        .mem_RegWrite  (mem_RegWrite),
        .mem_MemWrite  (mem_MemWrite),
        .mem_MemtoReg  (mem_MemtoReg),
        .wb_RegWrite   (wb_RegWrite),
        .wb_MemtoReg   (wb_MemtoReg)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2b, BEQ = 6'h04;
    localparam logic [5:0] BNE = 6'h05, ADDI = 6'h08, J = 6'h02, BAD = 6'h3f;
    localparam logic [5:0] F_ADD = 6'h20;

    typedef struct packed {
        logic       rw, rd, asrc, br, bne, j, mw, m2r;
        logic [2:0] alu;
        logic [4:0] rt;
    } stg_t;

    // Reference pipeline: [0]=MEM/WB, [1]=EX/MEM, [2]=ID/EX contents.
    stg_t pipe_q[$];
    bit   m_illegal;
    int   tests_run = 0;
    int   tests_failed = 0;
    logic obs_stall;
    logic exp_stall;

    stg_t       obs_ex;
    logic [2:0] obs_mem;
    logic [1:0] obs_wb;
    assign obs_ex  = {ex_RegWrite, ex_RegDest, ex_ALUSrc, ex_Branch, ex_BranchNe,
                      ex_Jump, ex_MemWrite, ex_MemtoReg, ex_ALUControl, ex_rt};
    assign obs_mem = {mem_RegWrite, mem_MemWrite, mem_MemtoReg};
    assign obs_wb  = {wb_RegWrite, wb_MemtoReg};

    function automatic bit ref_rt_used(input logic [5:0] op);
        return (op == R) || (op == SW) || (op == BEQ) || (op == BNE);
    endfunction

    function automatic bit ref_illegal(input logic [5:0] op, input logic [5:0] fn);
        if (op == R)
            return !(fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a});
        return !(op inside {LW, SW, BEQ, BNE, ADDI, J});
    endfunction

    function automatic stg_t ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [4:0] r);
        stg_t s;
        s = '0;
        case (op)
            R: begin
                case (fn)
                    6'h20: s.alu = 3'b010;
                    6'h22: s.alu = 3'b110;
                    6'h24: s.alu = 3'b000;
                    6'h25: s.alu = 3'b001;
                    6'h2a: s.alu = 3'b111;
                    default: ;
                endcase
                if (!ref_illegal(op, fn)) begin
                    s.rw = 1'b1;
                    s.rd = 1'b1;
                end
            end
            LW:   begin s.rw = 1'b1; s.asrc = 1'b1; s.m2r = 1'b1; s.alu = 3'b010; end
            SW:   begin s.asrc = 1'b1; s.mw = 1'b1; s.alu = 3'b010; end
            BEQ:  begin s.br = 1'b1; s.alu = 3'b110; end
            BNE:  begin s.bne = 1'b1; s.alu = 3'b110; end
            ADDI: begin s.rw = 1'b1; s.asrc = 1'b1; s.alu = 3'b010; end
            J:    s.j = 1'b1;
            default: ;
        endcase
        s.rt = r;
        return s;
    endfunction

    // Drives one ID cycle, samples stall mid-cycle, clocks, and advances the model.
    task automatic cycle(input bit r, input bit v, input bit f, input logic [5:0] op,
                         input logic [5:0] fn, input logic [4:0] s_rs, input logic [4:0] s_rt);
        stg_t ex;
        stg_t nxt;
        rst = r; valid_id = v; flush_id = f; opcode = op; func = fn; rs = s_rs; rt = s_rt;
        #1;
        obs_stall = stall;
        ex = pipe_q[2];
        exp_stall = v && !f && ex.m2r && ex.rw && (ex.rt != 0)
                    && ((ex.rt == s_rs) || (ref_rt_used(op) && (ex.rt == s_rt)));
        @(posedge clk);
        #1;
        if (r) begin
            pipe_q = '{stg_t'(0), stg_t'(0), stg_t'(0)};
            m_illegal = 1'b0;
        end else begin
            if (!v || f || exp_stall) nxt = '0;
            else nxt = ref_decode(op, fn, s_rt);
            if (v && !f && !exp_stall && ref_illegal(op, fn)) m_illegal = 1'b1;
            pipe_q.push_back(nxt);
            void'(pipe_q.pop_front());
        end
    endtask

    task automatic test_reset();
        cycle(1, 1, 0, R, F_ADD, 5'd1, 5'd2);
        cycle(1, 1, 0, R, F_ADD, 5'd1, 5'd2);
        tests_run++;
        if (obs_ex !== '0) begin
            tests_failed++;
            $display("FAIL reset_ex: got %h want 0", obs_ex);
        end
        tests_run++;
        if ({obs_mem, obs_wb} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_mem_wb: got %b want 00000", {obs_mem, obs_wb});
        end
        cycle(0, 1, 0, R, F_ADD, 5'd1, 5'd2);
        tests_run++;
        if (obs_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_stall: got %b want 0", obs_stall);
        end
        tests_run++;
        if (ex_RegWrite !== 1'b1 || ex_ALUControl !== 3'b010) begin
            tests_failed++;
            $display("FAIL first_add: RegWrite %b ALU %b want 1 010", ex_RegWrite, ex_ALUControl);
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        tests_run++;
        if (illegal_op !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_illegal: got %b want 0", illegal_op);
        end
`endif
    endtask

    task automatic test_latency();
        cycle(0, 1, 0, LW, 6'h0, 5'd1, 5'd8);
        tests_run++;
        if (ex_MemtoReg !== 1'b1 || ex_rt !== 5'd8) begin
            tests_failed++;
            $display("FAIL lat_ex: MemtoReg %b rt %0d want 1 8", ex_MemtoReg, ex_rt);
        end
        cycle(0, 1, 0, R, F_ADD, 5'd2, 5'd3);
        tests_run++;
        if (mem_MemtoReg !== 1'b1 || ex_MemtoReg !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat_mem: mem %b ex %b want 1 0", mem_MemtoReg, ex_MemtoReg);
        end
        cycle(0, 1, 0, R, F_ADD, 5'd2, 5'd3);
        tests_run++;
        if (wb_MemtoReg !== 1'b1 || wb_RegWrite !== 1'b1) begin
            tests_failed++;
            $display("FAIL lat_wb: MemtoReg %b RegWrite %b want 1 1", wb_MemtoReg, wb_RegWrite);
        end
        cycle(0, 1, 0, R, F_ADD, 5'd2, 5'd3);
        tests_run++;
        if (wb_MemtoReg !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat_drain: got %b want 0", wb_MemtoReg);
        end
    endtask

    task automatic test_load_use();
        cycle(0, 1, 0, LW, 6'h0, 5'd1, 5'd8);
        cycle(0, 1, 0, R, F_ADD, 5'd8, 5'd2);
        tests_run++;
        if (obs_stall !== 1'b1 || obs_ex !== '0) begin
            tests_failed++;
            $display("FAIL lu_stall: stall %b ex %h want 1 0", obs_stall, obs_ex);
        end
        cycle(0, 1, 0, R, F_ADD, 5'd8, 5'd2);
        tests_run++;
        if (obs_stall !== 1'b0 || ex_RegWrite !== 1'b1 || ex_RegDest !== 1'b1 || ex_rt !== 5'd2) begin
            tests_failed++;
            $display("FAIL lu_release: stall %b ex %h want 0 and add rt=2", obs_stall, obs_ex);
        end
        cycle(0, 1, 0, LW, 6'h0, 5'd1, 5'd0);
        cycle(0, 1, 0, R, F_ADD, 5'd0, 5'd0);
        tests_run++;
        if (obs_stall !== 1'b0 || ex_RegWrite !== 1'b1) begin
            tests_failed++;
            $display("FAIL lu_zero: stall %b RegWrite %b want 0 1", obs_stall, ex_RegWrite);
        end
    endtask

    task automatic test_rt_use();
        cycle(0, 1, 0, LW, 6'h0, 5'd1, 5'd9);
        cycle(0, 1, 0, ADDI, 6'h0, 5'd3, 5'd9);
        tests_run++;
        if (obs_stall !== 1'b0 || ex_ALUSrc !== 1'b1 || ex_RegWrite !== 1'b1) begin
            tests_failed++;
            $display("FAIL rt_addi: stall %b ex %h want 0 and addi", obs_stall, obs_ex);
        end
        cycle(0, 1, 0, LW, 6'h0, 5'd1, 5'd9);
        cycle(0, 1, 0, SW, 6'h0, 5'd3, 5'd9);
        tests_run++;
        if (obs_stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL rt_sw_stall: got %b want 1", obs_stall);
        end
        cycle(0, 1, 0, SW, 6'h0, 5'd3, 5'd9);
        tests_run++;
        if (obs_stall !== 1'b0 || ex_MemWrite !== 1'b1) begin
            tests_failed++;
            $display("FAIL rt_sw_issue: stall %b MemWrite %b want 0 1", obs_stall, ex_MemWrite);
        end
    endtask

    task automatic test_flush();
        cycle(0, 1, 0, LW, 6'h0, 5'd1, 5'd9);
        cycle(0, 1, 1, R, F_ADD, 5'd9, 5'd2);
        tests_run++;
        if (obs_stall !== 1'b0 || obs_ex !== '0) begin
            tests_failed++;
            $display("FAIL flush: stall %b ex %h want 0 0", obs_stall, obs_ex);
        end
        cycle(0, 0, 0, R, F_ADD, 5'd1, 5'd2);
        tests_run++;
        if (obs_ex !== '0) begin
            tests_failed++;
            $display("FAIL invalid: ex %h want 0", obs_ex);
        end
    endtask

    task automatic test_illegal();
        cycle(0, 1, 0, BAD, 6'h0, 5'd1, 5'd2);
        tests_run++;
        if (obs_ex[15:5] !== 11'b0) begin
            tests_failed++;
            $display("FAIL illegal_op_zero: ex %h want controls 0", obs_ex);
        end
        cycle(0, 1, 0, R, 6'h3f, 5'd1, 5'd2);
        tests_run++;
        if (obs_ex[15:5] !== 11'b0) begin
            tests_failed++;
            $display("FAIL illegal_fn_zero: ex %h want controls 0", obs_ex);
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        cycle(0, 1, 0, R, F_ADD, 5'd1, 5'd2);
        cycle(0, 0, 0, R, F_ADD, 5'd1, 5'd2);
        tests_run++;
        if (illegal_op !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_sticky: got %b want 1", illegal_op);
        end
`endif
        cycle(1, 0, 0, R, F_ADD, 5'd1, 5'd2);
`ifdef CTRL_ILLEGAL_TRAP_EN
        tests_run++;
        if (illegal_op !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_clear: got %b want 0", illegal_op);
        end
`endif
    endtask

    task automatic test_random();
        logic [5:0] ops[8];
        logic [5:0] fns[6];
        ops = '{R, LW, SW, BEQ, BNE, ADDI, J, BAD};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h3f};
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 50) == 0, ($urandom % 8) != 0, ($urandom % 10) == 0,
                  ops[$urandom % 8], fns[$urandom % 6],
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            tests_run++;
            if (obs_stall !== exp_stall) begin
                tests_failed++;
                $display("FAIL rnd_stall[%0d]: got %b want %b", i, obs_stall, exp_stall);
            end
            tests_run++;
            if (obs_ex !== pipe_q[2]) begin
                tests_failed++;
                $display("FAIL rnd_ex[%0d]: got %h want %h", i, obs_ex, pipe_q[2]);
            end
            tests_run++;
            if (obs_mem !== {pipe_q[1].rw, pipe_q[1].mw, pipe_q[1].m2r}) begin
                tests_failed++;
                $display("FAIL rnd_mem[%0d]: got %b want %b", i, obs_mem,
                         {pipe_q[1].rw, pipe_q[1].mw, pipe_q[1].m2r});
            end
            tests_run++;
            if (obs_wb !== {pipe_q[0].rw, pipe_q[0].m2r}) begin
                tests_failed++;
                $display("FAIL rnd_wb[%0d]: got %b want %b", i, obs_wb,
                         {pipe_q[0].rw, pipe_q[0].m2r});
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            tests_run++;
            if (illegal_op !== m_illegal) begin
                tests_failed++;
                $display("FAIL rnd_illegal[%0d]: got %b want %b", i, illegal_op, m_illegal);
            end
`endif
        end
    endtask

    initial begin
        pipe_q = '{stg_t'(0), stg_t'(0), stg_t'(0)};
        m_illegal = 1'b0;
        test_reset();
        test_latency();
        test_load_use();
        test_rt_use();
        test_flush();
        test_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
